mult_share_arbiter: RTL

Shares one 64-bit floating-point multiply instance (AXI-stream style, fixed latency, no backpressure) among N_REQ requesters, such as parallel backbone product chains. Arbitration is round-robin with burst locking, so a requester can issue a multi-beat product chain (last-flagged) without interleaving. Requester IDs and last flags are held in an in-order tag queue and used to route each multiplier result back to its originator. The block sits between the backbone/product datapaths and a single multiply IP instance.

---
 rtl/mult_share_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin, burst-locking share of one fixed-latency multiplier among N_REQ requesters,
// with an in-order tag queue routing each result back to its originator.
module mult_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int DATA_W = 64,
  parameter int TAG_DEPTH = 64,
  localparam int ID_W = $clog2(N_REQ),
  localparam int CNT_W = $clog2(TAG_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  input  logic [N_REQ-1:0]        req_last,
  output logic                    mul_tvalid,
  output logic [DATA_W-1:0]       mul_a_tdata,
  output logic [DATA_W-1:0]       mul_b_tdata,
  input  logic                    mul_result_tvalid,
  input  logic [DATA_W-1:0]       mul_result_tdata,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_last,
  output logic [CNT_W-1:0]        outstanding,
  output logic                    busy,
  output logic                    err_orphan
);
  localparam int PTR_W = CNT_W - 1;
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_nxt;
  logic [ID_W-1:0] rr_ptr, owner, gnt_id, fire_id;
  logic gnt_found, fire, fire_last, credit, pop;
  logic [ID_W:0] tag_mem [TAG_DEPTH];
  logic [ID_W:0] tag_rd;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  assign credit = outstanding != CNT_W'(TAG_DEPTH);
  assign fire = |req_ready;
  assign fire_id = state == LOCKED ? owner : gnt_id;
  assign fire_last = req_last[fire_id];
  assign pop = mul_result_tvalid && outstanding != '0;
  assign tag_rd = tag_mem[rd_ptr];
  assign busy = outstanding != '0 || state == LOCKED;
  // Rotating priority: the lowest offset from rr_ptr wins, hence the descending scan.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id = rr_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int j;
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (req_valid[j]) begin
        gnt_found = 1'b1;
        gnt_id = ID_W'(j);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
    end else begin
      state <= state_nxt;
      if (fire && fire_last) rr_ptr <= fire_id == ID_W'(N_REQ - 1) ? '0 : fire_id + 1'b1;
      if (fire && !fire_last) owner <= fire_id;
    end
  end
  always_comb state_nxt = fire ? (fire_last ? IDLE : LOCKED) : state;
  always_comb begin
    req_ready = '0;
    if (credit && state == LOCKED) req_ready[owner] = req_valid[owner];
    else if (credit && gnt_found) req_ready[gnt_id] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_tvalid <= 1'b0;
      mul_a_tdata <= '0;
      mul_b_tdata <= '0;
    end else begin
      mul_tvalid <= fire;
      if (fire) begin
        mul_a_tdata <= req_a[fire_id*DATA_W +: DATA_W];
        mul_b_tdata <= req_b[fire_id*DATA_W +: DATA_W];
      end
    end
  end
  always_ff @(posedge clk) if (fire) tag_mem[wr_ptr] <= {fire_id, fire_last};
  // A result with nothing outstanding is dropped and flagged rather than popping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      outstanding <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
      rsp_last <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      if (fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      outstanding <= outstanding + CNT_W'(fire) - CNT_W'(pop);
      rsp_valid <= pop ? N_REQ'(1) << tag_rd[ID_W:1] : '0;
      if (pop) begin
        rsp_data <= mul_result_tdata;
        rsp_last <= tag_rd[0];
      end
      err_orphan <= err_orphan | (mul_result_tvalid && outstanding == '0);
    end
  end
endmodule
